// File: rtl/adder_pkg.sv
// Shared types and helpers for the segmented pipelined adder.
package adder_pkg;

  // Default operand width and segment count for the adder environment.
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;

  // Payload fields are sized for the widest supported adder; bits above the
  // configured width are always zero and trim away in synthesis.
  localparam int unsigned PAY_W = 64;

  // Data carried between segments: accumulated low sum, the carry out of the
  // last segment added, and the operand segments not yet consumed (shifted
  // down so the next segment to add always sits in the low bits).
  typedef struct packed {
    logic [PAY_W-1:0] sum;
    logic             carry;
    logic [PAY_W-1:0] a;
    logic [PAY_W-1:0] b;
  } adder_pay_t;

  // True when the width/stage pair describes a buildable pipeline.
  function automatic logic cfg_ok(input int unsigned w, input int unsigned s);
    if (s == 0 || w == 0 || w > PAY_W) begin
      return 1'b0;
    end
    return (w % s) == 0;
  endfunction

  // Adds the low seg_w bits of a and b plus cin; returns {cout, sum} with
  // sum bits above seg_w cleared.
  function automatic logic [PAY_W:0] seg_add(input logic [PAY_W-1:0] a,
                                             input logic [PAY_W-1:0] b,
                                             input logic             cin,
                                             input int unsigned      seg_w);
    logic [PAY_W:0] mask;
    logic [PAY_W:0] full;
    logic           cout;
    mask = ~({(PAY_W + 1){1'b1}} << seg_w);
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (PAY_W + 1)'(cin);
    // Two seg_w-bit values plus one never exceed seg_w+1 bits, so any bit
    // above the mask is exactly the carry.
    cout = |(full & ~mask);
    return {cout, full[PAY_W-1:0] & mask[PAY_W-1:0]};
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One adder segment and its pipeline register.
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int unsigned SEG = 4,
  parameter int unsigned IDX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  adder_pay_t pay_i,
  input  logic       valid_i,
  input  logic       adv_i,
  output adder_pay_t pay_o,
  output logic       valid_o
);

  localparam int unsigned SHIFT = IDX * SEG;

  adder_pay_t       pay_d;
  adder_pay_t       pay_q;
  logic             valid_q;
  logic [PAY_W:0]   seg_res;

  // Add this segment and place its partial sum above the lower sums.
  always_comb begin
    pay_d       = pay_i;
    seg_res     = seg_add(pay_i.a, pay_i.b, pay_i.carry, SEG);
    pay_d.sum   = pay_i.sum | (seg_res[PAY_W-1:0] << SHIFT);
    pay_d.carry = seg_res[PAY_W];
    pay_d.a     = pay_i.a >> SEG;
    pay_d.b     = pay_i.b >> SEG;
  end

  // Stage register; holds everything while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
    end else if (adv_i) begin
      pay_q   <= pay_d;
      valid_q <= valid_i;
    end
  end

  assign pay_o   = pay_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/adder_pipe_resp.sv
// Segmented, pipelined ripple adder with valid/ready on both sides.
module adder_pipe_resp
  import adder_pkg::*;
#(
  parameter int unsigned width  = WIDTH,
  parameter int unsigned stages = STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] sum_out,
  output logic             carry_out
);

  localparam int unsigned SEG = (stages == 0) ? width : width / stages;

  // Reject configurations where segments would not tile the operands.
  if (!cfg_ok(width, stages)) begin : g_cfg_err
    $error("adder_pipe_resp: stages must be >= 1 and divide width");
  end

  adder_pay_t pay [stages+1];
  logic       vld [stages+1];
  logic       stall_c;
  logic       adv_c;
  logic       unused_tail;

  // A held result freezes every stage; otherwise all stages advance together.
  assign stall_c  = vld[stages] & ~out_ready;
  assign adv_c    = ~stall_c;
  assign in_ready = ~stall_c;

  // Stage 0 input: full operands, no sum yet, carry-in zero.
  assign pay[0] = '{sum: '0, carry: 1'b0, a: PAY_W'(in1), b: PAY_W'(in0)};
  assign vld[0] = in_valid;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    adder_seg_stage #(
      .SEG(SEG),
      .IDX(k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .pay_i  (pay[k]),
      .valid_i(vld[k]),
      .adv_i  (adv_c),
      .pay_o  (pay[k+1]),
      .valid_o(vld[k+1])
    );
  end

  // The last stage register drives the outputs directly.
  assign out_valid = vld[stages];
  assign sum_out   = pay[stages].sum[width-1:0];
  assign carry_out = pay[stages].carry;

  // Operand residue and sum bits above width are zero after the last stage.
  assign unused_tail = ^{pay[stages].a, pay[stages].b, pay[stages].sum >> width};

endmodule

// File: tb/tb_adder_pipe_resp.sv
// Bench for adder_pipe_resp: directed vectors plus randomized traffic on
// four instances (1, 2, 4 and 8 stages) checked against a queue model.
module tb_adder_pipe_resp;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in1;
  logic [7:0] in0;
  logic [3:0] out_ready;
  logic       in_ready_w  [4];
  logic       out_valid_w [4];
  logic       carry_w     [4];
  logic [7:0] sum_w       [4];

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  int pend [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    adder_pipe_resp #(
      .width (8),
      .stages(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_w[g]),
      .in1      (in1),
      .in0      (in0),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready[g]),
      .sum_out  (sum_w[g]),
      .carry_out(carry_w[g])
    );
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in1      = a;
    in0      = b;
  endtask

  // Checks result {carry,sum} of instance i.
  task automatic chk_res(input string nm, input int i, input logic [8:0] exp);
    chk({nm, "_valid"}, 16'(out_valid_w[i]), 16'd1);
    chk({nm, "_res"}, 16'({carry_w[i], sum_w[i]}), 16'(exp));
  endtask

  // Scoreboard: each accepted pair enqueues its true sum; each retire pops.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    logic [8:0] q [$];
    logic [8:0] e;
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else if (mon_en) begin
        if (out_valid_w[g] && q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rand_s%0d spurious: got %0h want no result", 1 << g,
                   {carry_w[g], sum_w[g]});
        end else if (out_valid_w[g] && out_ready[g]) begin
          e = q.pop_front();
          chk($sformatf("rand_s%0d", 1 << g), 16'({carry_w[g], sum_w[g]}), 16'(e));
        end
        if (in_valid && in_ready_w[g]) begin
          q.push_back(9'(in1) + 9'(in0));
        end
      end
      pend[g] = q.size();
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] res;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  initial begin
    vt[0] = '{a: 8'h0F, b: 8'h01, res: 9'h010};
    vt[1] = '{a: 8'hFF, b: 8'h01, res: 9'h100};
    vt[2] = '{a: 8'h80, b: 8'h80, res: 9'h100};
    vt[3] = '{a: 8'hFF, b: 8'hFF, res: 9'h1FE};
    vt[4] = '{a: 8'h00, b: 8'h00, res: 9'h000};
    vt[5] = '{a: 8'h12, b: 8'h34, res: 9'h046};
    vt[6] = '{a: 8'h7F, b: 8'h01, res: 9'h080};

    // Reset state.
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    out_ready = 4'hF;
    @(posedge clk);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid_%0d", i), 16'(out_valid_w[i]), 16'd0);
      chk($sformatf("rst_sum_%0d", i), 16'({carry_w[i], sum_w[i]}), 16'd0);
      chk($sformatf("rst_ready_%0d", i), 16'(in_ready_w[i]), 16'd1);
    end
    #3 rst = 1'b0;

    // Back-to-back table: 1-stage result one edge after accept, 2-stage two.
    for (int c = 0; c < NV + 2; c++) begin
      tick();
      if (c >= 1 && c - 1 < NV) chk_res($sformatf("tbl_s1_%0d", c - 1), 0, vt[c-1].res);
      else chk("tbl_s1_idle", 16'(out_valid_w[0]), 16'd0);
      if (c >= 2) chk_res($sformatf("tbl_s2_%0d", c - 2), 1, vt[c-2].res);
      else chk("tbl_s2_idle", 16'(out_valid_w[1]), 16'd0);
      if (c < NV) drive(1'b1, vt[c].a, vt[c].b);
      else drive(1'b0, 8'h00, 8'h00);
    end
    tick();
    chk("tbl_s2_drained", 16'(out_valid_w[1]), 16'd0);

    // Alternating valid: each result followed by a bubble.
    drive(1'b1, 8'h12, 8'h34);
    tick(); chk("bub_0", 16'(out_valid_w[1]), 16'd0); drive(1'b0, 8'h00, 8'h00);
    tick(); chk_res("bub_a", 1, 9'h046); drive(1'b1, 8'h7F, 8'h01);
    tick(); chk("bub_1", 16'(out_valid_w[1]), 16'd0); drive(1'b0, 8'h00, 8'h00);
    tick(); chk_res("bub_b", 1, 9'h080);
    tick(); chk("bub_2", 16'(out_valid_w[1]), 16'd0);

    // Backpressure: results held, input blocked, then drained in order.
    out_ready = 4'h0;
    drive(1'b1, 8'h11, 8'h22);
    tick(); chk("stl_rdy0", 16'(in_ready_w[1]), 16'd1); drive(1'b1, 8'hF0, 8'h20);
    tick(); chk_res("stl_hold0", 1, 9'h033); chk("stl_rdy1", 16'(in_ready_w[1]), 16'd0);
    drive(1'b1, 8'h05, 8'h06);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_res($sformatf("stl_hold%0d", i + 1), 1, 9'h033);
      chk("stl_blocked", 16'(in_ready_w[1]), 16'd0);
    end
    out_ready = 4'hF;
    #1 chk("stl_release_rdy", 16'(in_ready_w[1]), 16'd1);
    tick(); chk_res("stl_b", 1, 9'h110); drive(1'b0, 8'h00, 8'h00);
    tick(); chk_res("stl_c", 1, 9'h00B);
    tick(); chk("stl_empty", 16'(out_valid_w[1]), 16'd0);

    // Asynchronous reset with two results in flight.
    tick(); drive(1'b1, 8'h21, 8'h43);
    tick(); drive(1'b1, 8'h50, 8'h60);
    tick(); drive(1'b0, 8'h00, 8'h00); chk_res("rstf_pre", 1, 9'h064);
    #2 rst = 1'b1;
    #1;
    chk("rstf_valid", 16'(out_valid_w[1]), 16'd0);
    chk("rstf_sum", 16'({carry_w[1], sum_w[1]}), 16'd0);
    tick(); tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rstf_nostale", 16'(out_valid_w[1]), 16'd0);
    end
    drive(1'b1, 8'h01, 8'h02);
    tick(); chk("rstf_lat1", 16'(out_valid_w[1]), 16'd0); drive(1'b0, 8'h00, 8'h00);
    tick(); chk_res("rstf_new", 1, 9'h003);
    tick();

    // Randomized traffic on all four configurations.
    rst = 1'b1;
    tick();
    #3 rst = 1'b0;
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      case ($urandom_range(0, 7))
        0:       drive($urandom_range(0, 3) != 0, 8'hFF, 8'hFF);
        1:       drive($urandom_range(0, 3) != 0, 8'h00, 8'h00);
        default: drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      endcase
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00);
    out_ready = 4'hF;
    repeat (30) tick();
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("rand_left_s%0d", 1 << i), 16'(pend[i]), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
